// File: rtl/romulator_pkg.sv
// Shared types for the romulator SRAM path: requester ownership and arbiter states.
package romulator_pkg;
   localparam int RAM_ADDR_W = 16;

   typedef enum logic [1:0] {
      OWN_FLASH = 2'd0,
      OWN_CPU   = 2'd1,
      OWN_DIAG  = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } arb_state_t;

   // DRAIN keeps the CPU as owner until the settle window has fully elapsed.
   function automatic owner_t owner_of(arb_state_t s);
      case (s)
         BOOT:    return OWN_FLASH;
         HALTED:  return OWN_DIAG;
         default: return OWN_CPU;
      endcase
   endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester ports, SRAM strobes and CPU halt handshake of the SRAM arbiter.
interface ram_port_arbiter_if
   import romulator_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W
);
   // Strobes are single-cycle qualified: a requester's cs/we reach the SRAM on the
   // same cycle only while it owns the SRAM and gap is low; otherwise they are dropped.
   logic [ADDR_W-1:0] flash_addr, cpu_addr, diag_addr, ram_addr;
   logic [7:0]        flash_din, cpu_din, diag_din, ram_din;
   logic              flash_cs, flash_we, cpu_cs, cpu_we, diag_cs, diag_we;
   logic              ram_cs, ram_we;
   logic              diag_req, diag_ack, halt, rdy;
   owner_t            owner;
   arb_state_t        state;

   modport master (
      input  flash_addr, flash_din, flash_cs, flash_we,
      input  cpu_addr, cpu_din, cpu_cs, cpu_we,
      input  diag_addr, diag_din, diag_cs, diag_we, diag_req,
      output diag_ack, halt, rdy, ram_addr, ram_din, ram_cs, ram_we, owner, state
   );

   modport slave (
      output flash_addr, flash_din, flash_cs, flash_we,
      output cpu_addr, cpu_din, cpu_cs, cpu_we,
      output diag_addr, diag_din, diag_cs, diag_we, diag_req,
      input  diag_ack, halt, rdy, ram_addr, ram_din, ram_cs, ram_we, owner, state
   );
endinterface

// File: rtl/phi2_edge_sync.sv
// Synchronizes the asynchronous phi2 into clk and emits a registered one-cycle falling-edge pulse.
module phi2_edge_sync #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic phi2,
   output logic fall
);
   logic [DEPTH-1:0] sync_q;
   logic             prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= DEPTH'({sync_q, phi2});
         prev_q <= sync_q[DEPTH-1];
         fall   <= prev_q & ~sync_q[DEPTH-1];
      end
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// Registered ownership FSM for the shared 64 KB SRAM (flash loader, 6502, diagnostics)
// with CPU halt handshake and a one-cycle strobe gap on every ownership change.
module ram_port_arbiter
   import romulator_pkg::*;
#(
   parameter int ADDR_W        = RAM_ADDR_W,
   parameter int SETTLE_CYCLES = 4,
   parameter int PHI2_SYNC     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   boot_done,
   input  logic                   phi2,
   ram_port_arbiter_if.master     bus
);
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] SETTLE_DONE = CNT_W'(SETTLE_CYCLES);

   arb_state_t        state, state_nxt;
   owner_t            owner, owner_nxt;
   logic [CNT_W-1:0]  settle_cnt, settle_nxt;
   logic              rdy, halt, diag_ack, gap;
   logic              phi2_fall;

   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_din;
   logic              sel_cs, sel_we;

   phi2_edge_sync #(.DEPTH(PHI2_SYNC)) u_phi2_sync (
      .clk  (clk),
      .rst  (rst),
      .phi2 (phi2),
      .fall (phi2_fall)
   );

   // settle_cnt == 0 means "no phi2 fall seen yet in this DRAIN"; it then counts 1..SETTLE_CYCLES.
   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      case (state)
         BOOT: if (boot_done) state_nxt = RUN;
         RUN:  if (bus.diag_req) state_nxt = DRAIN;
         DRAIN: begin
            if (!bus.diag_req) begin
               state_nxt  = RUN;
               settle_nxt = '0;
            end else if (settle_cnt == SETTLE_DONE) begin
               state_nxt  = HALTED;
               settle_nxt = '0;
            end else if (settle_cnt != '0) begin
               settle_nxt = settle_cnt + 1'b1;
            end else if (phi2_fall) begin
               settle_nxt = CNT_W'(1);
            end
         end
         HALTED: if (!bus.diag_req) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
      if (!boot_done) begin
         state_nxt  = BOOT;
         settle_nxt = '0;
      end
   end

   assign owner_nxt = owner_of(state_nxt);

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         owner      <= OWN_FLASH;
         settle_cnt <= '0;
         rdy        <= 1'b0;
         halt       <= 1'b0;
         diag_ack   <= 1'b0;
         gap        <= 1'b1;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         settle_cnt <= settle_nxt;
         rdy        <= (state_nxt == RUN);
         halt       <= (state_nxt == DRAIN) || (state_nxt == HALTED);
         diag_ack   <= (state_nxt == HALTED);
         gap        <= (owner_nxt != owner);
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_din  = '0;
      sel_cs   = 1'b0;
      sel_we   = 1'b0;
      case (owner)
         OWN_FLASH: begin
            sel_addr = bus.flash_addr;
            sel_din  = bus.flash_din;
            sel_cs   = bus.flash_cs;
            sel_we   = bus.flash_we;
         end
         OWN_CPU: begin
            sel_addr = bus.cpu_addr;
            sel_din  = bus.cpu_din;
            sel_cs   = bus.cpu_cs;
            sel_we   = bus.cpu_we;
         end
         OWN_DIAG: begin
            sel_addr = bus.diag_addr;
            sel_din  = bus.diag_din;
            sel_cs   = bus.diag_cs;
            sel_we   = bus.diag_we;
         end
         default: ;
      endcase
   end

   // Address/data are also parked at zero during the gap so the SRAM bus is quiet across a handover.
   assign bus.ram_addr = gap ? '0 : sel_addr;
   assign bus.ram_din  = gap ? '0 : sel_din;
   assign bus.ram_cs   = sel_cs & ~gap;
   assign bus.ram_we   = sel_we & ~gap;
   assign bus.owner    = owner;
   assign bus.state    = state;
   assign bus.rdy      = rdy;
   assign bus.halt     = halt;
   assign bus.diag_ack = diag_ack;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: boot handover, halt/settle timing, diag access, abort and reset paths.
module tb_ram_port_arbiter;
   import romulator_pkg::*;

   logic clk = 1'b0;
   logic rst, boot_done, phi2;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic [23:0] exp_q[$];

   ram_port_arbiter_if #(.ADDR_W(16)) bus ();

   ram_port_arbiter #(.ADDR_W(16), .SETTLE_CYCLES(4), .PHI2_SYNC(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .boot_done (boot_done),
      .phi2      (phi2),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; boot_done = 1'b0; phi2 = 1'b0;
      bus.flash_addr = '0; bus.flash_din = '0; bus.flash_cs = 1'b0; bus.flash_we = 1'b0;
      bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
      bus.diag_addr = '0; bus.diag_din = '0; bus.diag_cs = 1'b0; bus.diag_we = 1'b0;
      bus.diag_req = 1'b0;
      tick(); tick();
      total++; if (bus.state !== BOOT) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.state, BOOT); end
      total++; if (bus.owner !== OWN_FLASH) begin bad++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
      total++; if ({bus.rdy, bus.halt, bus.diag_ack} !== 3'b000) begin bad++; $display("FAIL reset_hs: got rdy/halt/ack=%b want 000", {bus.rdy, bus.halt, bus.diag_ack}); end
      total++; if ({bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din} !== 26'd0) begin bad++; $display("FAIL reset_ram: got cs=%b we=%b addr=%h din=%h want all zero", bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din); end
   endtask

   task automatic test_boot();
      rst = 1'b0;
      bus.flash_addr = 16'h1234; bus.flash_din = 8'hA5; bus.flash_cs = 1'b1; bus.flash_we = 1'b1;
      bus.cpu_addr = 16'h4321; bus.cpu_din = 8'h77; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0;
      tick();
      total++; if ({bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din} !== {2'b11, 16'h1234, 8'hA5}) begin bad++; $display("FAIL boot_flash_write: got cs=%b we=%b addr=%h din=%h want 1 1 1234 a5", bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din); end
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL boot_rdy_low: got %b want 0", bus.rdy); end
      boot_done = 1'b1;
      tick();
      total++; if (bus.owner !== OWN_CPU || bus.rdy !== 1'b1) begin bad++; $display("FAIL boot_handover: got owner=%0d rdy=%b want 1 1", bus.owner, bus.rdy); end
      total++; if (bus.ram_cs !== 1'b0) begin bad++; $display("FAIL boot_gap: got ram_cs=%b want 0", bus.ram_cs); end
      tick();
      total++; if ({bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din} !== {2'b10, 16'h4321, 8'h77}) begin bad++; $display("FAIL boot_cpu_access: got cs=%b we=%b addr=%h din=%h want 1 0 4321 77", bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din); end
   endtask

   task automatic test_halt();
      int c0;
      int ack_cyc;
      phi2 = 1'b1;
      bus.flash_cs = 1'b0; bus.flash_we = 1'b0;
      bus.diag_addr = 16'h8000; bus.diag_din = 8'h3C; bus.diag_cs = 1'b1; bus.diag_we = 1'b1;
      repeat (4) tick();
      bus.diag_req = 1'b1;
      tick();
      total++; if (bus.state !== DRAIN || bus.rdy !== 1'b0 || bus.halt !== 1'b1 || bus.owner !== OWN_CPU) begin bad++; $display("FAIL drain_entry: got state=%0d rdy=%b halt=%b owner=%0d want 2 0 1 1", bus.state, bus.rdy, bus.halt, bus.owner); end
      repeat (2) tick();
      phi2 = 1'b0;
      c0 = cyc;
      ack_cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k % 8 == 0) phi2 = ~phi2;
         if (bus.diag_ack === 1'b1) begin
            ack_cyc = cyc;
            break;
         end
      end
      total++; if (ack_cyc - c0 !== 8) begin bad++; $display("FAIL halt_latency: got %0d cycles want 8 (ack_cyc=%0d)", ack_cyc - c0, ack_cyc); end
      total++; if (bus.owner !== OWN_DIAG || bus.ram_cs !== 1'b0 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL halt_gap: got owner=%0d cs=%b we=%b want 2 0 0", bus.owner, bus.ram_cs, bus.ram_we); end
      bus.diag_cs = 1'b0; bus.diag_we = 1'b0;
      bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (bus.ram_cs !== 1'b0 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL halted_cpu_ignored: got cs=%b we=%b want 0 0", bus.ram_cs, bus.ram_we); end
      end
   endtask

   task automatic test_diag_write();
      logic [23:0] exp;
      bus.diag_cs = 1'b1; bus.diag_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.diag_addr = 16'h8000 + 16'(i);
         bus.diag_din  = 8'h3C ^ 8'(i);
         exp_q.push_back({16'h8000 + 16'(i), 8'h3C ^ 8'(i)});
         tick();
         exp = exp_q.pop_front();
         total++; if ({bus.ram_addr, bus.ram_din} !== exp || bus.ram_we !== 1'b1 || bus.ram_cs !== 1'b1) begin bad++; $display("FAIL diag_write: got addr=%h din=%h we=%b cs=%b want %h %h 1 1", bus.ram_addr, bus.ram_din, bus.ram_we, bus.ram_cs, exp[23:8], exp[7:0]); end
      end
   endtask

   task automatic test_release();
      bus.diag_req = 1'b0;
      bus.cpu_addr = 16'h0200; bus.cpu_din = 8'h11;
      tick();
      total++; if (bus.rdy !== 1'b1 || bus.diag_ack !== 1'b0 || bus.halt !== 1'b0 || bus.owner !== OWN_CPU) begin bad++; $display("FAIL release_hs: got rdy=%b ack=%b halt=%b owner=%0d want 1 0 0 1", bus.rdy, bus.diag_ack, bus.halt, bus.owner); end
      total++; if (bus.ram_cs !== 1'b0) begin bad++; $display("FAIL release_gap: got ram_cs=%b want 0", bus.ram_cs); end
      tick();
      total++; if (bus.ram_cs !== 1'b1 || bus.ram_addr !== 16'h0200) begin bad++; $display("FAIL release_cpu_access: got cs=%b addr=%h want 1 0200", bus.ram_cs, bus.ram_addr); end
   endtask

   task automatic test_abort();
      logic ack_seen;
      ack_seen = 1'b0;
      phi2 = 1'b1;
      repeat (4) tick();
      bus.diag_req = 1'b1;
      tick();
      ack_seen |= bus.diag_ack;
      total++; if (bus.state !== DRAIN) begin bad++; $display("FAIL abort_drain: got state=%0d want 2", bus.state); end
      tick();
      ack_seen |= bus.diag_ack;
      bus.diag_req = 1'b0;
      tick();
      ack_seen |= bus.diag_ack;
      total++; if (bus.state !== RUN || bus.rdy !== 1'b1 || bus.halt !== 1'b0) begin bad++; $display("FAIL abort_return: got state=%0d rdy=%b halt=%b want 1 1 0", bus.state, bus.rdy, bus.halt); end
      total++; if (bus.ram_cs !== 1'b1) begin bad++; $display("FAIL abort_no_gap: got ram_cs=%b want 1", bus.ram_cs); end
      total++; if (ack_seen !== 1'b0) begin bad++; $display("FAIL abort_ack_glitch: got ack_seen=%b want 0", ack_seen); end
   endtask

   task automatic test_rst_halted();
      logic got_ack;
      got_ack = 1'b0;
      bus.diag_req = 1'b1;
      tick();
      phi2 = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.diag_ack === 1'b1) begin
            got_ack = 1'b1;
            break;
         end
      end
      total++; if (got_ack !== 1'b1) begin bad++; $display("FAIL rst_reach_halted: got diag_ack=%b want 1 within 30 cycles", bus.diag_ack); end
      bus.diag_cs = 1'b1; bus.diag_we = 1'b1;
      bus.flash_cs = 1'b1; bus.flash_we = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      total++; if (bus.owner !== OWN_FLASH || bus.state !== BOOT) begin bad++; $display("FAIL rst_owner: got owner=%0d state=%0d want 0 0", bus.owner, bus.state); end
      total++; if (bus.ram_we !== 1'b0 || bus.halt !== 1'b0 || bus.diag_ack !== 1'b0 || bus.rdy !== 1'b0) begin bad++; $display("FAIL rst_outputs: got we=%b halt=%b ack=%b rdy=%b want 0 0 0 0", bus.ram_we, bus.halt, bus.diag_ack, bus.rdy); end
      rst = 1'b0;
      bus.diag_req = 1'b0;
      bus.diag_cs = 1'b0; bus.diag_we = 1'b0;
      tick();
      total++; if (bus.state !== RUN || bus.rdy !== 1'b1) begin bad++; $display("FAIL rst_rerun: got state=%0d rdy=%b want 1 1", bus.state, bus.rdy); end
   endtask

   task automatic test_boot_drop();
      tick();
      boot_done = 1'b0;
      bus.flash_addr = 16'hBEEF;
      tick();
      total++; if (bus.state !== BOOT || bus.owner !== OWN_FLASH || bus.rdy !== 1'b0) begin bad++; $display("FAIL boot_drop: got state=%0d owner=%0d rdy=%b want 0 0 0", bus.state, bus.owner, bus.rdy); end
      total++; if (bus.ram_cs !== 1'b0) begin bad++; $display("FAIL boot_drop_gap: got ram_cs=%b want 0", bus.ram_cs); end
      tick();
      total++; if (bus.ram_cs !== 1'b1 || bus.ram_addr !== 16'hBEEF) begin bad++; $display("FAIL boot_drop_flash: got cs=%b addr=%h want 1 beef", bus.ram_cs, bus.ram_addr); end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_halt();
      test_diag_write();
      test_release();
      test_abort();
      test_rst_halted();
      test_boot_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
